// File: rtl/wb_pad_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wb_pad_ctrl_pkg
// Shared constants for the Wishbone pad controller: register offsets inside the
// 256-byte window, the output-enable reset pattern, the ERR bit index, and a
// helper that expands Wishbone byte selects into a 32-bit lane mask.
// -----------------------------------------------------------------------------
package wb_pad_ctrl_pkg;

    // Register offsets (byte address bits [7:0] within the window)
    localparam logic [7:0] OFF_DOUT    = 8'h00;
    localparam logic [7:0] OFF_OEB     = 8'h04;
    localparam logic [7:0] OFF_DIN     = 8'h08;
    localparam logic [7:0] OFF_RISE_EN = 8'h0C;
    localparam logic [7:0] OFF_FALL_EN = 8'h10;
    localparam logic [7:0] OFF_STATUS  = 8'h14;
    localparam logic [7:0] OFF_MASK    = 8'h18;
    localparam logic [7:0] OFF_ERR     = 8'h1C;

    // Every pad comes out of reset as an input (output enable is active-low)
    localparam logic [31:0] OEB_RST = 32'hFFFF_FFFF;

    // ERR register: bit set when an unmapped offset inside the window is accessed
    localparam int ERR_UNMAPPED = 0;

    // Expand the four Wishbone byte selects into a per-bit write mask
    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wb_pad_ctrl_edge_sync.sv
// -----------------------------------------------------------------------------
// pad_edge_sync
// Multi-flop input synchroniser followed by a "previous value" flop, producing
// the synchronised pad value and a per-pad edge event (enabled rising or
// falling transition).
//
// Ports:
//   clk      in   1         clock
//   rst_n    in   1         synchronous active-low reset
//   pad_in   in   W         raw, asynchronous pad inputs
//   rise_en  in   W         per-pad rising-edge enable
//   fall_en  in   W         per-pad falling-edge enable
//   din      out  W         synchronised pad value (last synchroniser stage)
//   evt      out  W         enabled edge seen this cycle (combinational)
// -----------------------------------------------------------------------------
module pad_edge_sync #(
    parameter int W        = 16,
    parameter int DIN_SYNC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] pad_in,
    input  logic [W-1:0] rise_en,
    input  logic [W-1:0] fall_en,
    output logic [W-1:0] din,
    output logic [W-1:0] evt
);

    // Stage 0 samples the pad; stage DIN_SYNC-1 is the synchronised value
    logic [DIN_SYNC-1:0][W-1:0] sync_q, sync_d;
    logic [W-1:0]               prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[DIN_SYNC-2:0], pad_in};
        prev_d = sync_q[DIN_SYNC-1];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbour; blocking here would
        // collapse the synchroniser chain into a single stage.
        if (!rst_n) begin
            // NOTE: the chain and prev flop are reset together (not left as
            // free-running storage) so both sides of the edge comparison are
            // 0 after reset and no spurious edge can be reported.
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign din = sync_q[DIN_SYNC-1];
    assign evt = (din & ~prev_q & rise_en) | (~din & prev_q & fall_en);

endmodule

// File: rtl/wb_pad_ctrl.sv
// -----------------------------------------------------------------------------
// wb_pad_ctrl
// Wishbone-attached controller for N_PADS user IO pads: output data, output
// enable, synchronised input readback and edge interrupts.
//
// Optional build macro: WB_PAD_CTRL_LA_OVERRIDE_EN
//   When defined, a pad whose la_oenb bit is 0 is driven from the logic
//   analyser (pad_out[i] = la_data_in[i], pad_oeb[i] = la_data_in[32+i]),
//   after the pad-output registers. When undefined, la_data_in/la_oenb are
//   ignored.
//
// Ports:
//   wb_clk_i     in   1       clock
//   wb_rst_ni    in   1       synchronous active-low reset
//   wbs_cyc_i    in   1       Wishbone cycle
//   wbs_stb_i    in   1       Wishbone strobe
//   wbs_we_i     in   1       Wishbone write enable
//   wbs_sel_i    in   4       byte enables
//   wbs_adr_i    in   32      byte address
//   wbs_dat_i    in   32      write data
//   wbs_ack_o    out  1       registered acknowledge
//   wbs_dat_o    out  32      registered read data (0 when not acking)
//   pad_in       in   N_PADS  raw pad inputs
//   pad_out      out  N_PADS  pad output data
//   pad_oeb      out  N_PADS  pad output enable, active-low
//   la_data_in   in   64      logic-analyser data
//   la_oenb      in   64      logic-analyser enables (active-low)
//   la_data_out  out  64      synchronised pad inputs, zero-extended
//   irq          out  3       {0, unmapped-access error, masked edge status}
// -----------------------------------------------------------------------------
module wb_pad_ctrl
    import wb_pad_ctrl_pkg::*;
#(
    parameter int          N_PADS    = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          DIN_SYNC  = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [N_PADS-1:0] pad_in,
    output logic [N_PADS-1:0] pad_out,
    output logic [N_PADS-1:0] pad_oeb,
    input  logic [63:0]       la_data_in,
    input  logic [63:0]       la_oenb,
    output logic [63:0]       la_data_out,
    output logic [2:0]        irq
);

    localparam logic [N_PADS-1:0] OEB_INIT = OEB_RST[N_PADS-1:0];

    // Register state
    logic [N_PADS-1:0] dout_q, dout_d;
    logic [N_PADS-1:0] oeb_q, oeb_d;
    logic [N_PADS-1:0] rise_en_q, rise_en_d;
    logic [N_PADS-1:0] fall_en_q, fall_en_d;
    logic [N_PADS-1:0] status_q, status_d;
    logic [N_PADS-1:0] mask_q, mask_d;
    logic              err_q, err_d;

    // Bus and interrupt state
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic              irq0_q, irq0_d;

    // Combinational helpers
    logic              bus_sel, xfer, wr, mapped, err_clr;
    logic [31:0]       lane, rdata;
    logic [N_PADS-1:0] wmask, wdata, status_clr;
    logic [N_PADS-1:0] din, evt;

    pad_edge_sync #(
        .W        (N_PADS),
        .DIN_SYNC (DIN_SYNC)
    ) u_edge_sync (
        .clk     (wb_clk_i),
        .rst_n   (wb_rst_ni),
        .pad_in  (pad_in),
        .rise_en (rise_en_q),
        .fall_en (fall_en_q),
        .din     (din),
        .evt     (evt)
    );

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves a variable unassigned, which would infer a latch.
        dout_d     = dout_q;
        oeb_d      = oeb_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        mask_d     = mask_q;
        status_clr = '0;
        err_clr    = 1'b0;
        mapped     = 1'b1;
        rdata      = '0;
        dat_d      = '0;

        bus_sel = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        // A selected cycle is a new transfer only while ack is low, which
        // forces the ack-high / ack-low pattern between back-to-back accesses.
        xfer    = bus_sel & ~ack_q;
        wr      = xfer & wbs_we_i;
        lane    = lane_mask(wbs_sel_i);
        wmask   = lane[N_PADS-1:0];
        wdata   = wbs_dat_i[N_PADS-1:0];

        // Full 8-bit compare also rejects misaligned addresses
        case (wbs_adr_i[7:0])
            OFF_DOUT: begin
                rdata[N_PADS-1:0] = dout_q;
                if (wr) dout_d = (dout_q & ~wmask) | (wdata & wmask);
            end
            OFF_OEB: begin
                rdata[N_PADS-1:0] = oeb_q;
                if (wr) oeb_d = (oeb_q & ~wmask) | (wdata & wmask);
            end
            OFF_DIN: begin
                rdata[N_PADS-1:0] = din;
            end
            OFF_RISE_EN: begin
                rdata[N_PADS-1:0] = rise_en_q;
                if (wr) rise_en_d = (rise_en_q & ~wmask) | (wdata & wmask);
            end
            OFF_FALL_EN: begin
                rdata[N_PADS-1:0] = fall_en_q;
                if (wr) fall_en_d = (fall_en_q & ~wmask) | (wdata & wmask);
            end
            OFF_STATUS: begin
                rdata[N_PADS-1:0] = status_q;
                if (wr) status_clr = wdata & wmask;
            end
            OFF_MASK: begin
                rdata[N_PADS-1:0] = mask_q;
                if (wr) mask_d = (mask_q & ~wmask) | (wdata & wmask);
            end
            OFF_ERR: begin
                rdata[ERR_UNMAPPED] = err_q;
                if (wr) err_clr = wbs_dat_i[ERR_UNMAPPED] & lane[ERR_UNMAPPED];
            end
            default: mapped = 1'b0;
        endcase

        // Sets are ORed in after the clear so a coincident edge wins
        status_d = (status_q & ~status_clr) | evt;
        err_d    = (err_q & ~err_clr) | (xfer & ~mapped);

        ack_d  = xfer;
        if (xfer && !wbs_we_i) dat_d = rdata;
        irq0_d = |(status_q & mask_q);
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            dout_q    <= '0;
            oeb_q     <= OEB_INIT;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            mask_q    <= '0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq0_q    <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            oeb_q     <= oeb_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            mask_q    <= mask_d;
            err_q     <= err_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq0_q    <= irq0_d;
        end
    end

`ifdef WB_PAD_CTRL_LA_OVERRIDE_EN
    // Logic-analyser override sits after the registers; DOUT/OEB keep their values
    always_comb begin
        pad_out = dout_q;
        pad_oeb = oeb_q;
        for (int i = 0; i < N_PADS; i++) begin
            if (!la_oenb[i]) begin
                pad_out[i] = la_data_in[i];
                pad_oeb[i] = la_data_in[32+i];
            end
        end
    end
`else
    assign pad_out = dout_q;
    assign pad_oeb = oeb_q;
`endif

    // Bits intentionally not consumed in every configuration
    logic unused_bits;
    assign unused_bits = ^{la_data_in, la_oenb, wbs_dat_i, lane};

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign la_data_out = {{(64-N_PADS){1'b0}}, din};
    assign irq         = {1'b0, err_q, irq0_q};

endmodule

// File: tb/tb_wb_pad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_pad_ctrl
// Self-checking bench for wb_pad_ctrl (default parameters). A behavioural
// model holds the register file as an array, the pad history as a queue
// (synchronised value = sample DIN_SYNC cycles old), and applies the register
// map rules per clock; every DUT output is compared with it each cycle.
// Directed scenarios are followed by randomized Wishbone and pad traffic.
// -----------------------------------------------------------------------------
module tb_wb_pad_ctrl;

    localparam int          N    = 16;
    localparam int          DS   = 2;
    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] M    = 32'h0000_FFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cyc, stb, we;
    logic [3:0]    sel;
    logic [31:0]   adr, dat_i, dat_o;
    logic          ack;
    logic [N-1:0]  pad_in, pad_out, pad_oeb;
    logic [63:0]   la_in, la_oenb, la_out;
    logic [2:0]    irq;

    int n_total = 0;
    int n_bad   = 0;

    // Model: register array indexed by offset/4 (slot 2 = DIN is unused)
    logic [31:0]  m_reg [8];
    logic         m_ack, m_irq0;
    logic [31:0]  m_dat;
    logic [N-1:0] m_hist [$];   // m_hist[0] = most recent pad sample

    always #5 clk = ~clk;

    wb_pad_ctrl dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_i),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .pad_in      (pad_in),
        .pad_out     (pad_out),
        .pad_oeb     (pad_oeb),
        .la_data_in  (la_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_out),
        .irq         (irq)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        foreach (m_reg[i]) m_reg[i] = '0;
        m_reg[1] = M;
        m_ack    = 1'b0;
        m_dat    = '0;
        m_irq0   = 1'b0;
        m_hist.delete();
        repeat (DS + 1) m_hist.push_back('0);
    endtask

    // Advance one clock: predict from pre-edge inputs/state, then compare all outputs
    task automatic cycle();
        logic [31:0]  nr [8];
        logic [31:0]  bm, din, prev, evt, clr_s, n_dat;
        logic         clr_e, unm, n_ack, n_irq0, in_rst;
        logic [N-1:0] pad_s, eo, ee;
        int           idx;

        in_rst = !rst_n;
        pad_s  = pad_in;
        nr     = m_reg;
        n_ack  = 1'b0;
        n_dat  = '0;
        clr_s  = '0;
        clr_e  = 1'b0;
        unm    = 1'b0;
        din    = 32'(m_hist[DS-1]);
        prev   = 32'(m_hist[DS]);
        evt    = ((din & ~prev & m_reg[3]) | (~din & prev & m_reg[4])) & M;
        n_irq0 = |(m_reg[5] & m_reg[6]);

        if (cyc && stb && adr[31:8] == BASE[31:8] && !m_ack) begin
            n_ack = 1'b1;
            bm    = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
            if (adr[1:0] == 2'b00 && adr[7:0] <= 8'h1C) begin
                idx = int'(adr[4:2]);
                if (!we) begin
                    n_dat = (idx == 2) ? din : m_reg[idx];
                end else begin
                    case (idx)
                        2:       ;
                        5:       clr_s = dat_i & bm;
                        7:       clr_e = dat_i[0] & bm[0];
                        default: nr[idx] = ((m_reg[idx] & ~bm) | (dat_i & bm)) & M;
                    endcase
                end
            end else begin
                unm = 1'b1;
            end
        end
        nr[5] = (m_reg[5] & ~clr_s) | evt;
        nr[7] = 32'((m_reg[7][0] & ~clr_e) | unm);

        @(posedge clk);
        #1;
        if (in_rst) begin
            model_reset();
        end else begin
            m_reg  = nr;
            m_ack  = n_ack;
            m_dat  = n_dat;
            m_irq0 = n_irq0;
            m_hist.push_front(pad_s);
            void'(m_hist.pop_back());
        end

        eo = m_reg[0][N-1:0];
        ee = m_reg[1][N-1:0];
`ifdef WB_PAD_CTRL_LA_OVERRIDE_EN
        eo = (eo & la_oenb[N-1:0]) | (la_in[N-1:0] & ~la_oenb[N-1:0]);
        ee = (ee & la_oenb[N-1:0]) | (la_in[32+N-1:32] & ~la_oenb[N-1:0]);
`endif
        check("ack",     64'(ack),     64'(m_ack));
        check("dat_o",   64'(dat_o),   64'(m_dat));
        check("pad_out", 64'(pad_out), 64'(eo));
        check("pad_oeb", 64'(pad_oeb), 64'(ee));
        check("irq",     64'(irq),     64'({1'b0, m_reg[7][0], m_irq0}));
        check("la_out",  la_out,       64'(m_hist[DS-1]));
    endtask

    // One Wishbone transfer: strobe for one cycle, capture ack/data, then idle one cycle
    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd, output logic acked);
        adr   = a;
        we    = w;
        dat_i = d;
        sel   = s;
        cyc   = 1'b1;
        stb   = 1'b1;
        cycle();
        acked = ack;
        rd    = dat_o;
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        cycle();
    endtask

    initial begin
        logic [31:0] rd;
        logic        ak;
        logic        do_rst;
        int          r, hold, gap;

        rst_n   = 1'b0;
        cyc     = 1'b0;
        stb     = 1'b0;
        we      = 1'b0;
        sel     = '0;
        adr     = '0;
        dat_i   = '0;
        pad_in  = '0;
        la_in   = '0;
        la_oenb = '1;
        model_reset();

        // Reset and idle
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();
        check("rst_oeb", 64'(pad_oeb), 64'h0000_FFFF);
        check("rst_out", 64'(pad_out), 64'h0);
        check("rst_irq", 64'(irq),     64'h0);

        // OEB readback, ack one cycle after strobe
        wb_xfer(BASE + 32'h04, 1'b0, '0, 4'hF, rd, ak);
        check("oeb_ack", 64'(ak), 64'h1);
        check("oeb_rd",  64'(rd), 64'h0000_FFFF);

        // Byte-lane write to DOUT
        wb_xfer(BASE + 32'h00, 1'b1, 32'h0000_A5C3, 4'b0001, rd, ak);
        check("dout_pad", 64'(pad_out), 64'h00C3);
        wb_xfer(BASE + 32'h00, 1'b0, '0, 4'hF, rd, ak);
        check("dout_rd", 64'(rd), 64'h0000_00C3);

        // Rising edge -> STATUS -> irq[0], latency DIN_SYNC+2 from the pad edge
        wb_xfer(BASE + 32'h0C, 1'b1, 32'h1, 4'hF, rd, ak);
        wb_xfer(BASE + 32'h18, 1'b1, 32'h1, 4'hF, rd, ak);
        pad_in[0] = 1'b1;
        repeat (DS + 1) cycle();
        check("irq0_early", 64'(irq[0]), 64'h0);
        cycle();
        check("irq0_set", 64'(irq[0]), 64'h1);
        wb_xfer(BASE + 32'h14, 1'b0, '0, 4'hF, rd, ak);
        check("status_rd", 64'(rd), 64'h1);
        wb_xfer(BASE + 32'h14, 1'b1, 32'h1, 4'hF, rd, ak);
        check("irq0_clr", 64'(irq[0]), 64'h0);

        // Edge and W1C landing on the same clock: set wins
        pad_in[0] = 1'b0;
        repeat (4) cycle();
        pad_in[0] = 1'b1;
        repeat (DS) cycle();
        wb_xfer(BASE + 32'h14, 1'b1, 32'h1, 4'hF, rd, ak);
        wb_xfer(BASE + 32'h14, 1'b0, '0, 4'hF, rd, ak);
        check("set_wins", 64'(rd[0]), 64'h1);

        // Unmapped offset inside the window
        wb_xfer(BASE + 32'h40, 1'b0, '0, 4'hF, rd, ak);
        check("unm_ack", 64'(ak),     64'h1);
        check("unm_rd",  64'(rd),     64'h0);
        check("unm_irq", 64'(irq[1]), 64'h1);

        // Outside the window: never acked
        adr = 32'h3000_1000;
        we  = 1'b0;
        cyc = 1'b1;
        stb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("oow_ack", 64'(ack), 64'h0);
        end
        cyc = 1'b0;
        stb = 1'b0;
        cycle();

        // Reset coinciding with a write strobe
        rst_n = 1'b0;
        adr   = BASE;
        we    = 1'b1;
        dat_i = 32'hFFFF_FFFF;
        sel   = 4'hF;
        cyc   = 1'b1;
        stb   = 1'b1;
        cycle();
        check("rst_wr_ack", 64'(ack), 64'h0);
        check("rst_wr_irq", 64'(irq), 64'h0);
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        rst_n = 1'b1;
        repeat (2) cycle();
        check("rst_wr_pad", 64'(pad_out), 64'h0);
        wb_xfer(BASE, 1'b0, '0, 4'hF, rd, ak);
        check("rst_wr_dout", 64'(rd), 64'h0);

        // Logic-analyser override of pad 3
        la_oenb = ~64'h8;
        la_in   = 64'h8;
        cycle();
`ifdef WB_PAD_CTRL_LA_OVERRIDE_EN
        check("la_out3", 64'(pad_out[3]), 64'h1);
        check("la_oeb3", 64'(pad_oeb[3]), 64'h0);
`else
        check("la_out3", 64'(pad_out[3]), 64'h0);
        check("la_oeb3", 64'(pad_oeb[3]), 64'h1);
`endif
        la_oenb = '1;
        la_in   = '0;

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 2) == 0) pad_in = pad_in ^ N'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                la_in   = {$urandom, $urandom};
                la_oenb = ($urandom_range(0, 1) == 1) ? '1 : {$urandom, $urandom};
            end
            r = $urandom_range(0, 11);
            if (r < 8)
                adr = BASE + 32'(r * 4);
            else if (r < 10)
                adr = BASE + 32'($urandom_range(0, 255));
            else
                adr = BASE + (32'($urandom_range(1, 255)) << 8);
            we     = ($urandom_range(0, 2) != 0);
            dat_i  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            sel    = 4'($urandom);
            hold   = $urandom_range(1, 4);
            gap    = $urandom_range(0, 2);
            do_rst = ($urandom_range(0, 59) == 0);
            cyc    = 1'b1;
            stb    = 1'b1;
            for (int h = 0; h < hold; h++) begin
                if (h == 0 && do_rst) rst_n = 1'b0;
                cycle();
                rst_n = 1'b1;
            end
            cyc = 1'b0;
            stb = 1'b0;
            we  = 1'b0;
            for (int g = 0; g < gap; g++) cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_pad_ctrl.md
Name: wb_pad_ctrl

Overview:
- Parametrised Wishbone-attached pad controller; successor to the fixed 16-pad user-project hookup.
- Owns output data, output-enable and edge-interrupt logic for N_PADS user IO pads, with a 2-flop input synchroniser.
- Sits between the management SoC Wishbone slave port and the user IO pads, beside the encryption core; drives user_irq.

Parameters:
- N_PADS, 16, number of controlled pads (1..32).
- BASE_ADDR, 32'h3000_0000, Wishbone window base; decode compares adr[31:8] only.
- DIN_SYNC, 2, input synchroniser depth (2 or 3).

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  synchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic strobes.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- pad_in  in  N_PADS  raw pad inputs.
- pad_out  out  N_PADS  pad output data.
- pad_oeb  out  N_PADS  pad output enable, active-low.
- la_data_in  in  64  logic-analyser data.
- la_oenb  in  64  logic-analyser enables.
- la_data_out  out  64  synchronised pad inputs, zero-extended.
- irq  out  3  interrupt lines.

Behaviour:
- Register map (offset, reset value; upper bits above N_PADS read 0 and ignore writes):
  - 0x00 DOUT, RW, 0.
  - 0x04 OEB, RW, all 1 (every pad an input).
  - 0x08 DIN, RO, synchronised pad_in.
  - 0x0C RISE_EN, RW, 0.
  - 0x10 FALL_EN, RW, 0.
  - 0x14 STATUS, W1C, 0.
  - 0x18 MASK, RW, 0.
  - 0x1C ERR, W1C, 0; bit0 = unmapped access seen.
- Selection: sel = cyc & stb & (adr[31:8]==BASE_ADDR[31:8]). Outside the window: no ack, wbs_dat_o=0.
- Handshake: ack registered. ack=1 in the cycle after a sel cycle in which ack was 0, then 0 for one cycle. Each transfer therefore has 1-cycle latency and a minimum 2-cycle spacing.
- Writes commit on the ack edge, per byte lane under wbs_sel_i.
- Read data is registered and valid with ack; it is 0 when no ack is asserted.
- Unmapped offset inside the window (0x20..0xFC or adr[1:0]!=0): acked; reads return 0; writes are dropped; ERR[0] is set.
- Synchroniser: DIN_SYNC flops, reset 0. One further flop holds the previous value for edge detection.
- Edge detect: rise[i] = din & ~prev & RISE_EN; fall[i] = ~din & prev & FALL_EN.
- STATUS[i] sets on rise|fall. If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- irq[0] = |(STATUS & MASK), registered (1 cycle after the status update). irq[1] = ERR[0]. irq[2] = 0.
- Pad outputs registered: pad_out=DOUT, pad_oeb=OEB.
- la_data_out[N_PADS-1:0] = synchronised din; remaining bits 0.
- Reset (any cycle, including mid-transfer):
  - All registers take their reset values; ack=0 next cycle; an in-flight transfer is dropped, not acked.
  - Outputs after reset: pad_out=0, pad_oeb=all 1, irq=0, wbs_dat_o=0, la_data_out=0.
- No edge events during the first DIN_SYNC+1 cycles after reset release, because the synchroniser and prev flop all start at 0.

Optional Feature:
- Macro: WB_PAD_CTRL_LA_OVERRIDE_EN.
- Defined: for i<N_PADS, when la_oenb[i]==0, pad_out[i]=la_data_in[i] and pad_oeb[i]=la_data_in[32+i]. The override is combinational after the pad-output registers, and DOUT/OEB register contents are unchanged.
- Undefined: la_data_in and la_oenb are ignored (left unconnected internally).

Decomposition:
- Package wb_pad_ctrl_pkg holds register offset localparams (OFF_DOUT..OFF_ERR), the OEB reset constant and the ERR bit index.
- One sub-module, pad_edge_sync: synchroniser plus prev flop plus rise/fall detection, parametrised on width and DIN_SYNC.

Test Plan:
- Reset release, no traffic -> pad_oeb=16'hFFFF, pad_out=0, irq=0; read 0x04 returns 32'h0000_FFFF with ack exactly 1 cycle after stb.
- Write 0x00 = 32'h0000_A5C3 with sel=4'b0001 -> pad_out=16'h00C3; read 0x00 returns 32'h0000_00C3.
- RISE_EN=1, MASK=1, pad_in[0] 0->1 -> STATUS=1 and irq[0]=1 at DIN_SYNC+2 cycles after the pad edge; write 0x14=1 -> irq[0] falls.
- Rising edge on pad 0 in the same cycle as a W1C of STATUS[0] -> STATUS[0] stays 1.
- Access 0x3000_0040 -> acked, read data 0, irq[1]=1; access 0x3000_1000 -> no ack for 8 cycles.
- Assert wb_rst_ni=0 in the cycle a write strobe is issued -> no ack, DOUT stays 0; with WB_PAD_CTRL_LA_OVERRIDE_EN defined, la_oenb[3]=0, la_data_in[3]=1, la_data_in[35]=0 -> pad_out[3]=1, pad_oeb[3]=0.
